// File: rtl/xbus_arbiter.sv
// xbus_arbiter: round-robin XBUS arbiter with address/data phase tracking and error flags
module xbus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT = 16,
  localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   sig_clock,
  input  logic                   sig_reset,
  input  logic [NUM_MASTERS-1:0] sig_request,
  output logic [NUM_MASTERS-1:0] sig_grant,
  output logic                   sig_start,
  input  logic                   sig_read,
  input  logic                   sig_write,
  input  logic [1:0]             sig_size,
  input  logic                   sig_bip,
  input  logic                   sig_wait,
  input  logic                   sig_error,
  output logic                   busy,
  output logic                   xfer_done,
  output logic [MW-1:0]          xfer_master,
  output logic                   proto_err,
  output logic                   timeout_err
);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, ARB, ADDR, DATA} state_t;
  state_t state, state_n;
  logic [MW-1:0] rr_ptr, winner;
  logic [3:0] beat_cnt, beat_next, expected;
  logic [WW-1:0] wait_cnt;
  logic done_n, perr_n, terr_n;
  assign sig_start = state == ARB;
  assign busy = state == ADDR || state == DATA;
  assign beat_next = beat_cnt + 4'd1;
  // first requester after rr_ptr; descending scan lets the nearest one win
  always_comb begin
    winner = rr_ptr;
    for (int i = NUM_MASTERS; i > 0; i--)
      if (|(sig_request & (NUM_MASTERS'(1) << ((int'(rr_ptr) + i) % NUM_MASTERS))))
        winner = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
  end
  // next state and end-of-transfer pulse decisions
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    perr_n = 1'b0;
    terr_n = 1'b0;
    case (state)
      IDLE: state_n = ARB;
      ARB: state_n = |sig_request ? ADDR : ARB;
      ADDR: begin
        state_n = sig_read ^ sig_write ? DATA : ARB;
        perr_n = sig_read & sig_write;
      end
      DATA: if (sig_wait) begin
        terr_n = TIMEOUT != 0 && wait_cnt == TO_LAST;
        state_n = terr_n ? ARB : DATA;
      end else begin
        done_n = !sig_error && !sig_bip && beat_next == expected;
        perr_n = !sig_error && (sig_bip == (beat_next == expected));
        state_n = sig_error || !sig_bip || beat_next == expected ? ARB : DATA;
      end
    endcase
  end
  // state, grant, counters and registered pulses
  always_ff @(posedge sig_clock or posedge sig_reset) begin
    if (sig_reset) begin
      state <= IDLE;
      sig_grant <= '0;
      rr_ptr <= MW'(NUM_MASTERS - 1);
      xfer_master <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      expected <= '0;
      xfer_done <= 1'b0;
      proto_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      xfer_done <= done_n;
      proto_err <= perr_n;
      timeout_err <= terr_n;
      if (state == ARB && |sig_request) begin
        sig_grant <= NUM_MASTERS'(1) << winner;
        xfer_master <= winner;
        rr_ptr <= winner;
      end else if (state_n == ARB) sig_grant <= '0;
      if (state == ADDR) begin
        expected <= 4'd1 << sig_size;
        beat_cnt <= '0;
        wait_cnt <= '0;
      end
      if (state == DATA) begin
        beat_cnt <= sig_wait ? beat_cnt : beat_next;
        wait_cnt <= sig_wait ? wait_cnt + 1'b1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: randomized self-checking bench with a transfer-level reference model
module tb_xbus_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] sig_request = '0, sig_grant, sig_size = '0;
  logic sig_start, sig_read = 0, sig_write = 0, sig_bip = 0, sig_wait = 0, sig_error = 0;
  logic busy, xfer_done, proto_err, timeout_err;
  logic [0:0] xfer_master;
  int checks = 0, errors = 0, m_ptr = 1, gcyc = 0;
  xbus_arbiter #(.NUM_MASTERS(2), .TIMEOUT(TO)) dut (
    .sig_clock(clk), .sig_reset(rst), .sig_request(sig_request), .sig_grant(sig_grant),
    .sig_start(sig_start), .sig_read(sig_read), .sig_write(sig_write), .sig_size(sig_size),
    .sig_bip(sig_bip), .sig_wait(sig_wait), .sig_error(sig_error), .busy(busy),
    .xfer_done(xfer_done), .xfer_master(xfer_master), .proto_err(proto_err),
    .timeout_err(timeout_err));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(input logic [1:0] r);
    for (int i = 1; i <= 2; i++)
      if (((r >> ((m_ptr + i) % 2)) & 2'b01) != 2'b00) return (m_ptr + i) % 2;
    return -1;
  endfunction
  // one transfer from ARB back to ARB; outcome: 0 none, 1 done, 2 proto, 3 timeout
  task automatic xfer(input logic [1:0] r, input logic rd, input logic wr, input logic [1:0] size,
                      input int last, input int err_beat, input int wmode, input string tag);
    int w, beat, c, wt, exp_n, outcome;
    logic [1:0] eg;
    logic [2:0] ep;
    bit fin;
    checks++;
    if (sig_start !== 1'b1) begin errors++; $display("FAIL %s start_before_grant: got %b want 1", tag, sig_start); end
    w = pick(r);
    m_ptr = w;
    eg = 2'(1 << w);
    sig_request = r;
    step();
    sig_request = '0;
    checks++;
    if (sig_grant !== eg || xfer_master !== 1'(w) || sig_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s grant: got grant=%b master=%0d start=%b busy=%b want grant=%b master=%0d start=0 busy=1",
               tag, sig_grant, xfer_master, sig_start, busy, eg, w);
    end
    gcyc = 1;
    sig_read = rd;
    sig_write = wr;
    sig_size = size;
    step();
    sig_read = 0;
    sig_write = 0;
    exp_n = 1 << size;
    outcome = 0;
    if (rd == wr) outcome = rd ? 2 : 0;
    else begin
      fin = 0;
      beat = 1;
      c = 0;
      wt = wmode < 0 ? int'($urandom_range(0, 2)) : wmode;
      while (!fin && beat <= 16) begin
        checks++;
        if (sig_grant !== eg || busy !== 1'b1 || {xfer_done, proto_err, timeout_err} !== 3'b000) begin
          errors++;
          $display("FAIL %s data_hold: got grant=%b busy=%b pulses=%b want grant=%b busy=1 pulses=000",
                   tag, sig_grant, busy, {xfer_done, proto_err, timeout_err}, eg);
        end
        gcyc++;
        if (c < wt) begin
          sig_wait = 1;
          c++;
          if (c == TO) begin outcome = 3; fin = 1; end
        end else begin
          sig_wait = 0;
          sig_bip = beat < last;
          sig_error = beat == err_beat;
          if (beat == err_beat) begin outcome = 0; fin = 1; end
          else if (beat >= last) begin outcome = beat == exp_n ? 1 : 2; fin = 1; end
          else if (beat == exp_n) begin outcome = 2; fin = 1; end
          beat++;
          c = 0;
          wt = wmode < 0 ? int'($urandom_range(0, 2)) : wmode;
        end
        step();
      end
      sig_wait = 0;
      sig_bip = 0;
      sig_error = 0;
    end
    ep = outcome == 1 ? 3'b100 : outcome == 2 ? 3'b010 : outcome == 3 ? 3'b001 : 3'b000;
    checks++;
    if ({xfer_done, proto_err, timeout_err} !== ep || sig_grant !== 2'b00 || busy !== 1'b0 || sig_start !== 1'b1) begin
      errors++;
      $display("FAIL %s end: got pulses=%b grant=%b busy=%b start=%b want pulses=%b grant=00 busy=0 start=1",
               tag, {xfer_done, proto_err, timeout_err}, sig_grant, busy, sig_start, ep);
    end
    step();
    checks++;
    if ({xfer_done, proto_err, timeout_err} !== 3'b000 || sig_start !== 1'b1 || sig_grant !== 2'b00) begin
      errors++;
      $display("FAIL %s pulse_width: got pulses=%b start=%b grant=%b want 000 1 00",
               tag, {xfer_done, proto_err, timeout_err}, sig_start, sig_grant);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    step();
    checks++;
    if (sig_grant !== 2'b00 || busy !== 0 || sig_start !== 0 || xfer_master !== 0 ||
        {xfer_done, proto_err, timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got grant=%b busy=%b start=%b master=%0d pulses=%b want all 0",
               sig_grant, busy, sig_start, xfer_master, {xfer_done, proto_err, timeout_err});
    end
    rst = 0;
    m_ptr = 1;
    step();
    checks++;
    if (sig_start !== 1'b1) begin errors++; $display("FAIL idle_to_arb: got start=%b want 1", sig_start); end
  endtask
  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) xfer(2'b11, 0, 0, 2'd0, 1, 0, 0, "rr_nop");
    xfer(2'b01, 0, 0, 2'd0, 1, 0, 0, "rr_single");
    xfer(2'b01, 0, 0, 2'd0, 1, 0, 0, "rr_repeat");
  endtask
  task automatic test_burst();
    m_ptr = 0;
    xfer(2'b10, 0, 1, 2'd2, 4, 0, 0, "burst4");
    checks++;
    if (gcyc !== 5) begin errors++; $display("FAIL burst4_grant_cycles: got %0d want 5", gcyc); end
    xfer(2'b01, 1, 0, 2'd3, 8, 0, 1, "burst8_waits");
  endtask
  task automatic test_proto();
    xfer(2'b01, 1, 0, 2'd1, 1, 0, 0, "short_burst");
    xfer(2'b10, 0, 1, 2'd0, 2, 0, 0, "overrun");
    xfer(2'b11, 1, 1, 2'd0, 1, 0, 0, "rd_and_wr");
  endtask
  task automatic test_timeout();
    xfer(2'b01, 1, 0, 2'd0, 1, 0, 100, "timeout");
    checks++;
    if (gcyc !== 5) begin errors++; $display("FAIL timeout_cycles: got %0d want 5", gcyc); end
    xfer(2'b10, 0, 1, 2'd1, 2, 0, 3, "wait3_ok");
  endtask
  task automatic test_slave_error();
    xfer(2'b11, 0, 1, 2'd2, 4, 2, 0, "slave_err");
  endtask
  task automatic test_async_reset();
    m_ptr = 1;
    sig_request = 2'b10;
    step();
    sig_request = '0;
    sig_write = 1;
    sig_size = 2'd2;
    step();
    sig_write = 0;
    sig_wait = 1;
    step();
    checks++;
    if (busy !== 1'b1 || sig_grant !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_data: got busy=%b grant=%b want 1 10", busy, sig_grant);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (sig_grant !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got grant=%b busy=%b want 00 0", sig_grant, busy);
    end
    sig_wait = 0;
    step();
    rst = 0;
    checks++;
    if (sig_start !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got start=%b want 0", sig_start); end
    step();
    m_ptr = 1;
    xfer(2'b11, 0, 1, 2'd0, 1, 0, 0, "post_reset_first");
  endtask
  task automatic test_random();
    logic [1:0] rw, sz;
    int last, eb, wm, n;
    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        step();
        checks++;
        if (sig_start !== 1'b1 || sig_grant !== 2'b00) begin
          errors++;
          $display("FAIL rand_idle_arb: got start=%b grant=%b want 1 00", sig_start, sig_grant);
        end
      end
      rw = 2'($urandom_range(0, 7) < 6 ? $urandom_range(1, 2) : $urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      last = $urandom_range(0, 2) != 0 ? (1 << sz) : int'($urandom_range(1, 8));
      eb = $urandom_range(0, 5) == 0 ? int'($urandom_range(1, 8)) : 0;
      wm = $urandom_range(0, 9) == 0 ? 100 : -1;
      xfer(2'($urandom_range(1, 3)), rw[1], rw[0], sz, last, eb, wm, "random");
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_proto();
    test_timeout();
    test_slave_error();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
